// File: rtl/cordic_iter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_iter
// Description : Iterative rotation-mode CORDIC, one micro-rotation per clock,
//               producing cos/sin of a signed fixed-point angle in radians.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_iter #(
    parameter int WIDTH = 24,
    parameter int ITER  = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH+1:0] in_angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] out_cos,
    output logic [WIDTH+1:0] out_sin
);
    localparam int IW = WIDTH + 4;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int FB = 60;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [IW-1:0] c_k =
        IW'(((64'd6072529350 << WIDTH) + 64'd5000000000) / 64'd10000000000);

    // atan(1/n) * 2^FB by its Taylor series; used for the i = 0 entry via Machin.
    function automatic logic [63:0] atan_inv(input logic [63:0] n);
        logic [63:0] term;
        logic [63:0] sum;
        term = (64'd1 << FB) / n;
        sum  = 64'd0;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 1) sum = sum - term / 64'(2 * k + 1);
            else            sum = sum + term / 64'(2 * k + 1);
            term = term / (n * n);
        end
        return sum;
    endfunction

    function automatic logic [63:0] atan_pow2(input int i);
        logic [63:0] term;
        logic [63:0] sum;
        term = 64'd1 << (FB - i);
        sum  = 64'd0;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 1) sum = sum - term / 64'(2 * k + 1);
            else            sum = sum + term / 64'(2 * k + 1);
            term = term >> (2 * i);
        end
        return sum;
    endfunction

    function automatic logic [63:0] atan_round(input int i);
        logic [63:0] v;
        v = (i == 0) ? (64'd4 * atan_inv(64'd5) - atan_inv(64'd239)) : atan_pow2(i);
        return (v + (64'd1 << (FB - WIDTH - 1))) >> (FB - WIDTH);
    endfunction

    logic signed [IW-1:0] w_atan_tab [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam logic [IW-1:0] c_val = IW'(atan_round(g));
        assign w_atan_tab[g] = c_val;
    end

    logic [1:0]           r_state;
    logic [CW-1:0]        r_iter;
    logic signed [IW-1:0] r_x;
    logic signed [IW-1:0] r_y;
    logic signed [IW-1:0] r_z;
    logic [WIDTH+1:0]     r_cos;
    logic [WIDTH+1:0]     r_sin;

    logic signed [IW-1:0] w_xs;
    logic signed [IW-1:0] w_ys;
    logic signed [IW-1:0] w_x_nxt;
    logic signed [IW-1:0] w_y_nxt;
    logic signed [IW-1:0] w_z_nxt;
    logic                 w_last;

    always_comb begin
        w_xs = r_x >>> r_iter;
        w_ys = r_y >>> r_iter;
        if (r_z[IW-1]) begin
            w_x_nxt = r_x + w_ys;
            w_y_nxt = r_y - w_xs;
            w_z_nxt = r_z + w_atan_tab[r_iter];
        end else begin
            w_x_nxt = r_x - w_ys;
            w_y_nxt = r_y + w_xs;
            w_z_nxt = r_z - w_atan_tab[r_iter];
        end
    end

    assign w_last = (r_iter == CW'(ITER - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_x     <= c_k;
                        r_y     <= '0;
                        r_z     <= {{2{in_angle[WIDTH+1]}}, in_angle};
                        r_iter  <= '0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    r_x    <= w_x_nxt;
                    r_y    <= w_y_nxt;
                    r_z    <= w_z_nxt;
                    r_iter <= r_iter + 1'b1;
                    if (w_last) begin
                        r_cos   <= w_x_nxt[WIDTH+1:0];
                        r_sin   <= w_y_nxt[WIDTH+1:0];
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (out_ready) r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign out_cos   = r_cos;
    assign out_sin   = r_sin;

endmodule
`default_nettype wire

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 24: fractional bits of all fixed-point ports.
REQ-002 SHALL have parameter ITER, default 24: number of CORDIC micro-rotations per angle (1..WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  angle on in_angle is offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an angle.
REQ-007 SHALL have port in_angle  input  WIDTH+2  signed two's-complement radians, WIDTH fractional bits (unpacker output format).
REQ-008 SHALL have port out_valid  output  1  out_cos/out_sin hold a finished result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_cos  output  WIDTH+2  signed cos(angle), WIDTH fractional bits.
REQ-011 SHALL have port out_sin  output  WIDTH+2  signed sin(angle), WIDTH fractional bits.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 SHALL accept an angle on an edge where in_valid & in_ready: load x = K, y = 0, z = in_angle, iteration counter i = 0, go to RUN.
REQ-014 SHALL use K = round(0.6072529350 * 2^WIDTH); for WIDTH = 24, K = 0x9B74EE.
REQ-015 SHALL, on each RUN edge, perform one rotation: d = +1 if z >= 0 else -1; x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*atan_tab[i]; i' = i + 1.
REQ-016 SHALL use arithmetic (sign-preserving) right shifts and WIDTH+4-bit signed internal x/y/z (2 extra integer bits), truncating to WIDTH+2 only at output.
REQ-017 SHALL hold atan_tab[i] = round(atan(2^-i) * 2^WIDTH) for i = 0..ITER-1 as a constant table (atan_tab[0] = 0xC90FDB for WIDTH = 24).
REQ-018 SHALL move RUN -> DONE on the edge completing rotation i = ITER-1; out_valid rises exactly ITER edges after the accept edge.
REQ-019 SHALL register out_cos = x, out_sin = y on entry to DONE and hold them stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL move DONE -> IDLE on an edge with out_ready = 1; in_ready rises the following cycle (throughput one angle per ITER+2 cycles).
REQ-021 SHALL ignore in_valid in RUN and DONE; in_angle is sampled only on the accept edge and may change afterwards.
REQ-022 SHALL guarantee accuracy of ±16 LSB on both outputs for |in_angle| <= 1.0 (0x1000000); outside [-pi/2, pi/2] results are unspecified but the FSM SHALL still complete in ITER cycles.
REQ-023 SHALL keep out_cos/out_sin unchanged in IDLE and RUN (previous result remains visible; only out_valid qualifies it).

Reset
REQ-024 SHALL, on any edge with reset_n = 0, regardless of state, enter IDLE with out_valid = 0, in_ready = 1 on the following cycle, out_cos = 0, out_sin = 0, i = 0, x = y = z = 0.
REQ-025 SHALL discard any in-flight rotation on reset; no result from the aborted angle is ever presented.

Verification
REQ-026 SHALL pass: in_angle = 0x0000000, out_ready = 1 -> out_valid after 24 edges, out_cos = 0x1000000 ±16, out_sin = 0 ±16.
REQ-027 SHALL pass: in_angle = 0x0800000 (0.5) -> out_cos = 14723392 ±16, out_sin = 8043426 ±16.
REQ-028 SHALL pass: in_angle = 0x3000000 (-1.0) -> out_cos = 9064769 ±16, out_sin = -14117540 ±16 (two's complement in 26 bits).
REQ-029 SHALL pass: out_ready held 0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready = 0, second in_valid pulse ignored; release out_ready -> in_ready = 1 next cycle.
REQ-030 SHALL pass: reset_n = 0 for one edge at i = 12 of a RUN -> next cycle in_ready = 1, out_valid = 0, outputs = 0; following angle 0x0800000 yields REQ-027 results.
REQ-031 SHALL pass: back-to-back angles with in_valid held high and out_ready = 1 -> each accepted exactly once, spacing ITER+2 cycles, results in order.
